// File: rtl/synth_ctrl_pkg.sv
// Shared constants and helpers for the synthesiser control register file.
package synth_ctrl_pkg;

    localparam int KEY_OFF  = 0;
    localparam int FREQ_OFF = 1;
    localparam int AMP1_OFF = 2;
    localparam int AMP0_OFF = 3;

    localparam int CTRL_PENDING = 0;
    localparam int CTRL_AUTO    = 1;

    localparam int FREQ_W = 7;
    localparam int AMP_W  = 16;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/synth_key_edge.sv
// Registered copy of the live key bits and one-cycle on/off strobes.
module synth_key_edge #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_on,
    output logic [N-1:0] key_off
);

    logic [N-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev <= '0;
        else
            prev <= key;
    end

    assign key_on  = key & ~prev;
    assign key_off = ~key & prev;

endmodule

// File: rtl/synth_ctrl_regs.sv
// Avalon-MM control register file: shadow/live banks with sample-tick commit.
module synth_ctrl_regs
    import synth_ctrl_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int NUM_GLOBAL = 32,
    parameter int ADDR_W     = 7
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [ADDR_W-1:0]         AVL_ADDR,
    input  logic [3:0]                AVL_BYTE_EN,
    input  logic                      AVL_READ,
    input  logic                      AVL_WRITE,
    input  logic                      AVL_CS,
    input  logic [31:0]               AVL_WRITEDATA,
    output logic [31:0]               AVL_READDATA,
    output logic                      AVL_READDATAVALID,
    input  logic                      SAMPLE_TICK,
    output logic [32*NUM_GLOBAL-1:0]  GLOBAL_REGS,
    output logic [NUM_VOICES-1:0]     VOICE_KEY,
    output logic [7*NUM_VOICES-1:0]   VOICE_FREQ,
    output logic [16*NUM_VOICES-1:0]  VOICE_AMP1,
    output logic [16*NUM_VOICES-1:0]  VOICE_AMP0,
    output logic [NUM_VOICES-1:0]     KEY_ON_PULSE,
    output logic [NUM_VOICES-1:0]     KEY_OFF_PULSE,
    output logic                      COMMIT_PENDING
);

    localparam int VEND      = NUM_GLOBAL + 4*NUM_VOICES;
    localparam int CTRL_ADDR = 2**ADDR_W - 1;

    logic [31:0]       glob_sh [NUM_GLOBAL];
    logic [31:0]       glob_lv [NUM_GLOBAL];
    logic              key_sh  [NUM_VOICES];
    logic              key_lv  [NUM_VOICES];
    logic [FREQ_W-1:0] freq_sh [NUM_VOICES];
    logic [FREQ_W-1:0] freq_lv [NUM_VOICES];
    logic [AMP_W-1:0]  amp1_sh [NUM_VOICES];
    logic [AMP_W-1:0]  amp1_lv [NUM_VOICES];
    logic [AMP_W-1:0]  amp0_sh [NUM_VOICES];
    logic [AMP_W-1:0]  amp0_lv [NUM_VOICES];
    logic              pending;
    logic              auto_commit;

    logic [ADDR_W-1:0] vofs;
    logic [ADDR_W-3:0] vidx;
    logic [1:0]        fsel;
    logic              is_voice;
    logic              is_ctrl;
    logic              wr;
    logic              commit;
    logic [31:0]       shadow_val;
    logic [31:0]       merged;

    assign vofs     = AVL_ADDR - ADDR_W'(NUM_GLOBAL);
    assign vidx     = vofs[ADDR_W-1:2];
    assign fsel     = vofs[1:0];
    assign is_voice = (AVL_ADDR >= ADDR_W'(NUM_GLOBAL)) && (AVL_ADDR < ADDR_W'(VEND));
    assign is_ctrl  = (AVL_ADDR == ADDR_W'(CTRL_ADDR));
    assign wr       = AVL_WRITE & AVL_CS & (|AVL_BYTE_EN);
    assign commit   = SAMPLE_TICK & pending;

    // Shadow view of the addressed register; feeds both readback and byte merge.
    always_comb begin
        shadow_val = '0;
        for (int g = 0; g < NUM_GLOBAL; g++)
            if (AVL_ADDR == ADDR_W'(g)) shadow_val = glob_sh[g];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (is_voice && vidx == (ADDR_W-2)'(v)) begin
                case (fsel)
                    2'(KEY_OFF):  shadow_val = {31'b0, key_sh[v]};
                    2'(FREQ_OFF): shadow_val = {{(32-FREQ_W){1'b0}}, freq_sh[v]};
                    2'(AMP1_OFF): shadow_val = {{(32-AMP_W){1'b0}}, amp1_sh[v]};
                    default:      shadow_val = {{(32-AMP_W){1'b0}}, amp0_sh[v]};
                endcase
            end
        end
        if (is_ctrl) shadow_val = {30'b0, auto_commit, pending};
    end

    assign merged = byte_merge(shadow_val, AVL_WRITEDATA, AVL_BYTE_EN);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int g = 0; g < NUM_GLOBAL; g++) begin
                glob_sh[g] <= '0;
                glob_lv[g] <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_sh[v]  <= 1'b0;
                key_lv[v]  <= 1'b0;
                freq_sh[v] <= '0;
                freq_lv[v] <= '0;
                amp1_sh[v] <= '0;
                amp1_lv[v] <= '0;
                amp0_sh[v] <= '0;
                amp0_lv[v] <= '0;
            end
            pending           <= 1'b0;
            auto_commit       <= 1'b1;
            AVL_READDATA      <= '0;
            AVL_READDATAVALID <= 1'b0;
        end else begin
            for (int g = 0; g < NUM_GLOBAL; g++) begin
                if (wr && AVL_ADDR == ADDR_W'(g)) begin
                    glob_sh[g] <= merged;
                    if (auto_commit) glob_lv[g] <= merged;
                end
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr && is_voice && vidx == (ADDR_W-2)'(v)) begin
                    case (fsel)
                        2'(KEY_OFF): begin
                            key_sh[v] <= merged[0];
                            if (auto_commit) key_lv[v] <= merged[0];
                        end
                        2'(FREQ_OFF): begin
                            freq_sh[v] <= merged[FREQ_W-1:0];
                            if (auto_commit) freq_lv[v] <= merged[FREQ_W-1:0];
                        end
                        2'(AMP1_OFF): begin
                            amp1_sh[v] <= merged[AMP_W-1:0];
                            if (auto_commit) amp1_lv[v] <= merged[AMP_W-1:0];
                        end
                        default: begin
                            amp0_sh[v] <= merged[AMP_W-1:0];
                            if (auto_commit) amp0_lv[v] <= merged[AMP_W-1:0];
                        end
                    endcase
                end
            end
            // Commit is assigned last so it overrides any same-cycle auto write to live.
            if (commit) begin
                for (int g = 0; g < NUM_GLOBAL; g++) glob_lv[g] <= glob_sh[g];
                for (int v = 0; v < NUM_VOICES; v++) begin
                    key_lv[v]  <= key_sh[v];
                    freq_lv[v] <= freq_sh[v];
                    amp1_lv[v] <= amp1_sh[v];
                    amp0_lv[v] <= amp0_sh[v];
                end
            end
            if (wr && is_ctrl && AVL_BYTE_EN[0]) auto_commit <= AVL_WRITEDATA[CTRL_AUTO];
            if (wr && is_ctrl && AVL_BYTE_EN[0] && AVL_WRITEDATA[CTRL_PENDING])
                pending <= 1'b1;
            else if (commit)
                pending <= 1'b0;
            AVL_READDATAVALID <= AVL_READ & AVL_CS;
            AVL_READDATA      <= (AVL_READ & AVL_CS) ? shadow_val : '0;
        end
    end

    for (genvar g = 0; g < NUM_GLOBAL; g++) begin : g_glob
        assign GLOBAL_REGS[32*g +: 32] = glob_lv[g];
    end
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign VOICE_KEY[v]            = key_lv[v];
        assign VOICE_FREQ[7*v +: 7]    = freq_lv[v];
        assign VOICE_AMP1[16*v +: 16]  = amp1_lv[v];
        assign VOICE_AMP0[16*v +: 16]  = amp0_lv[v];
    end

    assign COMMIT_PENDING = pending;

    synth_key_edge #(.N(NUM_VOICES)) u_key_edge (
        .clk     (CLK),
        .rst     (RESET),
        .key     (VOICE_KEY),
        .key_on  (KEY_ON_PULSE),
        .key_off (KEY_OFF_PULSE)
    );

endmodule

// File: doc/synth_ctrl_regs.md
Name: synth_ctrl_regs

Overview:
Parametrised Avalon-MM control register file for the synthesiser, generalising the fixed 8-voice/64-word control interface. It holds global settings plus a configurable number of per-voice register groups. Writes go to a shadow bank, with optional atomic commit to the live bank on an audio sample tick. It produces per-voice key-on/key-off strobes for the envelope generators.

Parameters:
NUM_VOICES, 8, number of voice register groups (1..16)
NUM_GLOBAL, 32, number of 32-bit global registers at addresses 0..NUM_GLOBAL-1
ADDR_W, 7, Avalon word address width; requires NUM_GLOBAL+4*NUM_VOICES < 2**ADDR_W

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous active-high reset
AVL_ADDR  in  ADDR_W  word address
AVL_BYTE_EN  in  4  byte enables for writes
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_CS  in  1  chip select
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data, valid with AVL_READDATAVALID
AVL_READDATAVALID  out  1  read response strobe
SAMPLE_TICK  in  1  one-cycle pulse per audio sample; the commit point
GLOBAL_REGS  out  32*NUM_GLOBAL  live global registers, reg i at [32i+31:32i]
VOICE_KEY  out  NUM_VOICES  live key-held bits
VOICE_FREQ  out  7*NUM_VOICES  live note numbers
VOICE_AMP1  out  16*NUM_VOICES  live amplitude 1 per voice
VOICE_AMP0  out  16*NUM_VOICES  live amplitude 0 per voice
KEY_ON_PULSE  out  NUM_VOICES  one-cycle strobe on live key 0->1
KEY_OFF_PULSE  out  NUM_VOICES  one-cycle strobe on live key 1->0
COMMIT_PENDING  out  1  mirror of CTRL.pending

Behaviour:
- Address map: 0..NUM_GLOBAL-1 are global registers. Voice v uses base NUM_GLOBAL+4v: +0 KEY[0], +1 FREQ[6:0], +2 AMP1[15:0], +3 AMP0[15:0]. CTRL is at 2**ADDR_W-1. All other addresses are unmapped.
- Voice registers store only their used bits. Unused bits read 0 and ignore writes.
- CTRL: bit0 pending (W1S, RO-clear), bit1 AUTO_COMMIT (RW). Other bits read 0.
- Write (AVL_WRITE & AVL_CS): byte-merge into the shadow register per AVL_BYTE_EN. A write with AVL_BYTE_EN=0 has no effect. Unmapped writes are ignored. Zero wait states.
- If AUTO_COMMIT=1, the same edge also writes the merged value into the live register. This gives legacy immediate behaviour.
- If AUTO_COMMIT=0, only the shadow changes. Writing CTRL with bit0=1 sets pending.
- Commit: on a cycle with SAMPLE_TICK & pending, all live registers take the shadow values and pending clears, at the same edge.
- Commit/write in the same cycle:
  - The commit copies pre-write shadow contents.
  - A data write in that cycle lands only in the shadow and waits for the next commit.
  - A CTRL write setting bit0 in that cycle wins: pending stays 1.
- Clearing AUTO_COMMIT does not clear pending. Setting AUTO_COMMIT does not force a commit.
- Read (AVL_READ & AVL_CS): registered, latency 1.
  - Shadow contents (or CTRL) appear on AVL_READDATA together with AVL_READDATAVALID=1 the following cycle.
  - Unmapped reads return 0 with valid asserted.
  - When AVL_READDATAVALID=0, AVL_READDATA holds 0.
- Simultaneous read and write to the same address returns the old value.
- Key pulses:
  - A registered copy of live VOICE_KEY is kept.
  - KEY_ON_PULSE[v] = live & ~prev; KEY_OFF_PULSE[v] = ~live & prev.
  - Each pulse is high for exactly one cycle, the cycle after live changes.
  - Several voices may pulse together.
- Reset (asynchronous, any time):
  - All shadow and live registers, the prev-key copy, pulses, AVL_READDATA, AVL_READDATAVALID and pending go to 0.
  - AUTO_COMMIT resets to 1.
  - A read in flight is dropped.

Decomposition:
- Package synth_ctrl_pkg holds:
  - voice field offsets (KEY_OFF=0, FREQ_OFF=1, AMP1_OFF=2, AMP0_OFF=3)
  - CTRL bit indices
  - field widths (FREQ_W=7, AMP_W=16)
  - a byte-merge function
- One sub-module, synth_key_edge (parameter N), for the prev-key register and on/off strobe generation.

Test Plan:
- Reset defaults: assert RESET mid-stream, then read CTRL -> 0x2. Read any global -> 0. All pulses and outputs are 0.
- Auto mode with byte enables: write 0xAABBCCDD with BE=4'b0101 to global 3 -> live and readback 0x00BB00DD one cycle after the write. AVL_READDATAVALID is exactly 1 cycle after AVL_READ.
- Shadow commit: write CTRL=0, write voice 2 FREQ=0x45, then CTRL=0x1 -> VOICE_FREQ[2] stays 0 until the first SAMPLE_TICK, then 0x45. COMMIT_PENDING drops at the same edge.
- Tick collision: with pending=1, write global 0=0x1234 in the SAMPLE_TICK cycle -> GLOBAL_REGS[0] keeps the old value, and the shadow reads 0x1234.
- Key strobes: in auto mode, write voice 0 KEY=1 and voice 5 KEY=1 -> KEY_ON_PULSE[0] and KEY_ON_PULSE[5] each pulse for 1 cycle. Write voice 0 KEY=0 -> KEY_OFF_PULSE[0] pulses for 1 cycle.
- Unmapped access: write to NUM_GLOBAL+4*NUM_VOICES -> no state change. A read of that address returns 0 with valid. Read voice FREQ after writing 0xFFFFFFFF -> 0x7F.
